memwb_skid_stage: RTL and testbench
===================================

// Module: memwb_skid_stage
// PURPOSE
//  Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//  Carries the memory read data, ALU result, destination register and writeback controls from MEM to WB.
//  Adds stall, flush and a pre-muxed writeback bus with register-zero write suppression.
//  Sits between data memory access and the register file write port.
// PARAMETERS
//  DATA_W     32  width of memory data, ALU result and writeback data
//  RADDR_W    5   width of the destination register index
//  ZERO_GUARD 1   1: a write to register index 0 never raises wb_we; 0: no suppression
// PORTS
//  clock          in   1        sole clock; all state updates on posedge
//  reset          in   1        synchronous, active-high
//  flush          in   1        synchronous discard of all held entries
//  in_valid       in   1        MEM-side entry present
//  in_ready       out  1        stage can accept an entry this cycle
//  in_mem_data    in   DATA_W   data memory read value
//  in_alu_result  in   DATA_W   ALU result / address
//  in_rd          in   RADDR_W  destination register index
//  in_mem_to_reg  in   1        1: writeback selects memory data; 0: ALU result
//  in_reg_write   in   1        entry writes the register file
//  out_valid      out  1        head entry valid toward WB
//  out_ready      in   1        WB consumes the head entry this cycle
//  out_mem_data   out  DATA_W   head entry fields, registered
//  out_alu_result out  DATA_W
//  out_rd         out  RADDR_W
//  out_mem_to_reg out  1
//  out_reg_write  out  1
//  wb_data        out  DATA_W   out_mem_to_reg ? out_mem_data : out_alu_result (combinational)
//  wb_rd          out  RADDR_W  equals out_rd
//  wb_we          out  1        out_valid & out_reg_write & (ZERO_GUARD ? out_rd!=0 : 1)
//  occupancy      out  2        entries held: 0, 1 or 2
// BEHAVIOUR
//  - Storage: head slot (drives out_*) and skid slot. State EMPTY(0), ONE(1), FULL(2); occupancy = state.
//  - in_ready = (state != FULL), a combinational function of the registered state only.
//    It never depends on out_ready.
//  - Accept = in_valid & in_ready. Drain = out_valid & out_ready. out_valid = (state != EMPTY).
//  - EMPTY: accept -> load head, go ONE.
//  - ONE:
//    - accept & drain -> load head, stay ONE.
//    - accept & !drain -> load skid, go FULL.
//    - drain only -> go EMPTY.
//  - FULL: drain -> skid moves to head, go ONE. No accept is possible because in_ready=0.
//  - FIFO ordering is strict; an entry is never dropped or duplicated outside flush/reset.
//  - Minimum latency: 1 cycle (entry accepted at edge N is presented at out_* after edge N).
//  - Data fields update only on load/shift; while stalled, out_* hold steady.
//  - flush: at the next edge state -> EMPTY. Any entry accepted in the flush cycle is discarded.
//    Drain in the flush cycle still counts as consumed. in_ready = 1 the cycle after.
//  - reset: priority over flush and every handshake.
//    Next edge: state EMPTY; all out_* and occupancy 0; wb_we 0; in_ready 1 after release.
//  - reset asserted mid-transfer: held entries are lost and in-cycle handshakes are ignored.
//  - wb_we is 0 whenever out_valid is 0, regardless of stale field values.
// TESTING
//  1. Reset, then in_valid=1 with alu=0x0000_1234, rd=5, reg_write=1, mem_to_reg=0, out_ready=1
//     -> next cycle out_valid=1, wb_data=0x1234, wb_rd=5, wb_we=1, occupancy=1.
//  2. out_ready=0; push A(rd=1) and B(rd=2)
//     -> occupancy=2, in_ready=0, a third push is not taken.
//     Then out_ready=1 -> A, then B, then out_valid=0.
//  3. mem_to_reg=1, mem_data=0xDEAD_BEEF, alu=0x10 -> wb_data=0xDEAD_BEEF.
//  4. ZERO_GUARD=1 with rd=0, reg_write=1 -> out_valid=1, wb_we=0.
//     With ZERO_GUARD=0 -> wb_we=1.
//  5. FULL plus flush with a simultaneous push
//     -> next cycle occupancy=0, out_valid=0, in_ready=1; the pushed entry never appears.
//  6. reset in the same cycle as push+flush -> all outputs 0, occupancy 0; no entry emerges afterwards.
//  7. Streaming 100 random entries with random out_ready -> output order and values match the input exactly.

Source files
------------

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage: valid/ready handshake with a 2-entry skid buffer (head + skid slot),
// flush, and a pre-muxed writeback bus with optional register-zero write suppression.
module memwb_skid_stage #(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 5,
    parameter bit ZERO_GUARD = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_mem_data,
    input  logic [DATA_W-1:0]  in_alu_result,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_mem_to_reg,
    input  logic               in_reg_write,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_mem_data,
    output logic [DATA_W-1:0]  out_alu_result,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_mem_to_reg,
    output logic               out_reg_write,
    output logic [DATA_W-1:0]  wb_data,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               wb_we,
    output logic [1:0]         occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  memData;
        logic [DATA_W-1:0]  aluResult;
        logic [RADDR_W-1:0] rd;
        logic               memToReg;
        logic               regWrite;
    } entry_t;

    state_t state;
    entry_t headEntry;
    entry_t skidEntry;
    entry_t inEntry;
    logic   accept;
    logic   drain;

    // Handshake: a transfer happens on a posedge where valid & ready are both high;
    // in_ready comes from registered state only, so it never depends on out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign occupancy = state;

    assign inEntry = '{memData:   in_mem_data,
                       aluResult: in_alu_result,
                       rd:        in_rd,
                       memToReg:  in_mem_to_reg,
                       regWrite:  in_reg_write};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= EMPTY;
            headEntry <= '0;
            skidEntry <= '0;
        end else if (flush) begin
            // Drain in this cycle is consumed; any accept in this cycle is dropped.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        headEntry <= inEntry;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        headEntry <= inEntry;
                    end else if (accept) begin
                        skidEntry <= inEntry;
                        state     <= FULL;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        headEntry <= skidEntry;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_mem_data   = headEntry.memData;
    assign out_alu_result = headEntry.aluResult;
    assign out_rd         = headEntry.rd;
    assign out_mem_to_reg = headEntry.memToReg;
    assign out_reg_write  = headEntry.regWrite;

    // Stale head fields after a drain or flush must never produce a write.
    assign wb_data = headEntry.memToReg ? headEntry.memData : headEntry.aluResult;
    assign wb_rd   = headEntry.rd;
    assign wb_we   = out_valid & headEntry.regWrite &
                     (ZERO_GUARD ? (headEntry.rd != '0) : 1'b1);

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed and streaming checks for memwb_skid_stage; a second instance with ZERO_GUARD=0
// shares all inputs so the register-zero write behaviour can be compared side by side.
module tb_memwb_skid_stage;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int ENT_W   = 2 * DATA_W + RADDR_W + 2;

    logic               clock = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_mem_data;
    logic [DATA_W-1:0]  in_alu_result;
    logic [RADDR_W-1:0] in_rd;
    logic               in_mem_to_reg;
    logic               in_reg_write;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_mem_data;
    logic [DATA_W-1:0]  out_alu_result;
    logic [RADDR_W-1:0] out_rd;
    logic               out_mem_to_reg;
    logic               out_reg_write;
    logic [DATA_W-1:0]  wb_data;
    logic [RADDR_W-1:0] wb_rd;
    logic               wb_we;
    logic [1:0]         occupancy;

    logic               ngInReady;
    logic               ngOutValid;
    logic [DATA_W-1:0]  ngOutMemData;
    logic [DATA_W-1:0]  ngOutAluResult;
    logic [RADDR_W-1:0] ngOutRd;
    logic               ngOutMemToReg;
    logic               ngOutRegWrite;
    logic [DATA_W-1:0]  ngWbData;
    logic [RADDR_W-1:0] ngWbRd;
    logic               ngWbWe;
    logic [1:0]         ngOccupancy;

    int passCount  = 0;
    int checkCount = 0;
    logic [ENT_W-1:0] exp_q[$];

    memwb_skid_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .ZERO_GUARD(1'b1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_data(in_mem_data), .in_alu_result(in_alu_result), .in_rd(in_rd),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mem_data(out_mem_data), .out_alu_result(out_alu_result), .out_rd(out_rd),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .occupancy(occupancy)
    );

    memwb_skid_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .ZERO_GUARD(1'b0)) dutNoGuard (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ngInReady),
        .in_mem_data(in_mem_data), .in_alu_result(in_alu_result), .in_rd(in_rd),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .out_valid(ngOutValid), .out_ready(out_ready),
        .out_mem_data(ngOutMemData), .out_alu_result(ngOutAluResult), .out_rd(ngOutRd),
        .out_mem_to_reg(ngOutMemToReg), .out_reg_write(ngOutRegWrite),
        .wb_data(ngWbData), .wb_rd(ngWbRd), .wb_we(ngWbWe), .occupancy(ngOccupancy)
    );

    // Clock / reset block
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] alu,
                         input logic [RADDR_W-1:0] rd, input logic m2r, input logic rw);
        in_valid      = v;
        in_mem_data   = mem;
        in_alu_result = alu;
        in_rd         = rd;
        in_mem_to_reg = m2r;
        in_reg_write  = rw;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step(); step();
        checkCount++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passCount++;
        checkCount++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d exp 0", occupancy); else passCount++;
        checkCount++; if ({out_mem_data, out_alu_result, out_rd, out_mem_to_reg, out_reg_write} !== '0)
            $display("FAIL reset_out_fields got %h exp 0", {out_mem_data, out_alu_result, out_rd}); else passCount++;
        checkCount++; if (wb_we !== 1'b0) $display("FAIL reset_wb_we got %b exp 0", wb_we); else passCount++;
        reset = 1'b0;
        step();
        checkCount++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passCount++;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 32'h0, 32'h0000_1234, 5'd5, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkCount++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %b exp 1", out_valid); else passCount++;
        checkCount++; if (wb_data !== 32'h0000_1234) $display("FAIL single_wb_data got %h exp 00001234", wb_data); else passCount++;
        checkCount++; if (wb_rd !== 5'd5) $display("FAIL single_wb_rd got %0d exp 5", wb_rd); else passCount++;
        checkCount++; if (wb_we !== 1'b1) $display("FAIL single_wb_we got %b exp 1", wb_we); else passCount++;
        checkCount++; if (occupancy !== 2'd1) $display("FAIL single_occupancy got %0d exp 1", occupancy); else passCount++;
        step();
        checkCount++; if (out_valid !== 1'b0) $display("FAIL single_drained got %b exp 0", out_valid); else passCount++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'hA, 5'd1, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h0, 32'hB, 5'd2, 1'b0, 1'b1);
        step();
        checkCount++; if (occupancy !== 2'd2) $display("FAIL bp_occupancy got %0d exp 2", occupancy); else passCount++;
        checkCount++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", in_ready); else passCount++;
        drive(1'b1, 32'h0, 32'hC, 5'd3, 1'b0, 1'b1);
        step();
        checkCount++; if (occupancy !== 2'd2) $display("FAIL bp_third_push got occ %0d exp 2", occupancy); else passCount++;
        checkCount++; if (out_rd !== 5'd1 || out_alu_result !== 32'hA)
            $display("FAIL bp_head_hold got rd %0d alu %h exp rd 1 alu a", out_rd, out_alu_result); else passCount++;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        checkCount++; if (out_rd !== 5'd2 || out_alu_result !== 32'hB || out_valid !== 1'b1)
            $display("FAIL bp_second got rd %0d alu %h v %b exp rd 2 alu b v 1", out_rd, out_alu_result, out_valid); else passCount++;
        step();
        checkCount++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", out_valid); else passCount++;
        step();
        checkCount++; if (out_valid !== 1'b0) $display("FAIL bp_no_third got %b exp 0", out_valid); else passCount++;
    endtask

    task automatic test_mem_to_reg();
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'h10, 5'd7, 1'b1, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkCount++; if (wb_data !== 32'hDEAD_BEEF) $display("FAIL m2r_wb_data got %h exp deadbeef", wb_data); else passCount++;
        checkCount++; if (out_alu_result !== 32'h10) $display("FAIL m2r_alu got %h exp 10", out_alu_result); else passCount++;
        step();
        checkCount++; if (wb_data !== 32'hDEAD_BEEF) $display("FAIL m2r_stall_hold got %h exp deadbeef", wb_data); else passCount++;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_zero_guard();
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h55, 5'd0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkCount++; if (out_valid !== 1'b1) $display("FAIL zg_out_valid got %b exp 1", out_valid); else passCount++;
        checkCount++; if (wb_we !== 1'b0) $display("FAIL zg_guard_wb_we got %b exp 0", wb_we); else passCount++;
        checkCount++; if (ngWbWe !== 1'b1) $display("FAIL zg_noguard_wb_we got %b exp 1", ngWbWe); else passCount++;
        out_ready = 1'b1;
        step();
        checkCount++; if (ngWbWe !== 1'b0) $display("FAIL zg_idle_wb_we got %b exp 0", ngWbWe); else passCount++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h1, 5'd1, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h0, 32'h2, 5'd2, 1'b0, 1'b1);
        step();
        checkCount++; if (occupancy !== 2'd2) $display("FAIL flush_prefill got %0d exp 2", occupancy); else passCount++;
        flush = 1'b1;
        drive(1'b1, 32'h0, 32'h99, 5'd9, 1'b0, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkCount++; if (occupancy !== 2'd0) $display("FAIL flush_occupancy got %0d exp 0", occupancy); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b exp 0", out_valid); else passCount++;
        checkCount++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b exp 1", in_ready); else passCount++;
        checkCount++; if (wb_we !== 1'b0) $display("FAIL flush_wb_we got %b exp 0", wb_we); else passCount++;
        // Accept-capable flush: ONE state with in_ready high, pushed entry must still vanish.
        drive(1'b1, 32'h0, 32'h3, 5'd3, 1'b0, 1'b1);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h0, 32'h4, 5'd4, 1'b0, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        checkCount++; if (out_valid !== 1'b0) $display("FAIL flush_one_out_valid got %b exp 0", out_valid); else passCount++;
        step();
        checkCount++; if (out_valid !== 1'b0) $display("FAIL flush_no_ghost got %b exp 0", out_valid); else passCount++;
    endtask

    task automatic test_reset_priority();
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 32'h66, 5'd6, 1'b1, 1'b1);
        step();
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h88, 32'h99, 5'd8, 1'b0, 1'b1);
        step();
        checkCount++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
            $display("FAIL rstprio_state got occ %0d v %b exp 0 0", occupancy, out_valid); else passCount++;
        checkCount++; if ({out_mem_data, out_alu_result, out_rd, out_mem_to_reg, out_reg_write} !== '0)
            $display("FAIL rstprio_fields got %h exp 0", {out_mem_data, out_alu_result}); else passCount++;
        checkCount++; if (wb_we !== 1'b0 || wb_data !== '0)
            $display("FAIL rstprio_wb got we %b data %h exp 0 0", wb_we, wb_data); else passCount++;
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkCount++; if (out_valid !== 1'b0) $display("FAIL rstprio_no_entry got %b exp 0 at %0d", out_valid, i); else passCount++;
        end
    endtask

    task automatic test_streaming();
        int sent = 0;
        int cycles = 0;
        int modelOcc = 0;
        logic accepted;
        logic drained;
        logic [ENT_W-1:0] ent;
        exp_q.delete();
        while ((sent < 100 || modelOcc != 0) && cycles < 2000) begin
            ent = {$urandom(), $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            drive(sent < 100 && $urandom_range(0, 3) != 0, ent[ENT_W-1 -: DATA_W], ent[ENT_W-1-DATA_W -: DATA_W],
                  ent[RADDR_W+1:2], ent[1], ent[0]);
            out_ready = ($urandom_range(0, 2) != 0);
            checkCount++; if (in_ready !== (modelOcc != 2))
                $display("FAIL stream_in_ready got %b exp %b", in_ready, modelOcc != 2); else passCount++;
            checkCount++; if (out_valid !== (modelOcc != 0))
                $display("FAIL stream_out_valid got %b exp %b", out_valid, modelOcc != 0); else passCount++;
            accepted = in_valid && (modelOcc != 2);
            drained  = out_ready && (modelOcc != 0);
            if (drained) begin
                checkCount++;
                if ({out_mem_data, out_alu_result, out_rd, out_mem_to_reg, out_reg_write} !== exp_q[0])
                    $display("FAIL stream_data got %h exp %h",
                             {out_mem_data, out_alu_result, out_rd, out_mem_to_reg, out_reg_write}, exp_q[0]);
                else passCount++;
                void'(exp_q.pop_front());
                modelOcc--;
            end
            if (accepted) begin
                exp_q.push_back(ent);
                sent++;
                modelOcc++;
            end
            step();
            cycles++;
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkCount++; if (cycles >= 2000) $display("FAIL stream_timeout got %0d sent exp 100 within budget", sent); else passCount++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_mem_to_reg();
        test_zero_guard();
        test_flush();
        test_reset_priority();
        test_streaming();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
